// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path: opcodes, FSM states,
// immediate-select, ALU-op, PC-source and writeback-select codes.
`timescale 1ns/1ps
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        IMM_R  = 3'b000,
        IMM_I  = 3'b001,
        IMM_S  = 3'b010,
        IMM_SB = 3'b011,
        IMM_UJ = 3'b100,
        IMM_U  = 3'b101
    } immtype_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_PLUS4   = 2'b00,
        PC_IMM     = 2'b01,
        PC_RS1_IMM = 2'b10
    } pc_src_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_IMM = 2'b11
    } wb_sel_t;

    typedef enum logic [3:0] {
        CLS_R, CLS_IALU, CLS_LOAD, CLS_STORE, CLS_BEQ, CLS_BNE,
        CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_ILLEGAL
    } iclass_t;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        pc_src_t    pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        alu_op_t    alu_op;
        wb_sel_t    wb_sel;
    } ctrl_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational classifier: opcode/funct3 -> instruction class, immediate
// select and legality.
`timescale 1ns/1ps
module opcode_decoder
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output iclass_t    iclass,
    output immtype_t   immtype,
    output logic       legal
);

    always_comb begin
        iclass  = CLS_ILLEGAL;
        immtype = IMM_R;
        legal   = 1'b0;
        case (opcode)
            OP_R:      begin iclass = CLS_R;     immtype = IMM_R;  legal = 1'b1; end
            OP_IALU:   begin iclass = CLS_IALU;  immtype = IMM_I;  legal = 1'b1; end
            OP_LOAD:   begin iclass = CLS_LOAD;  immtype = IMM_I;  legal = 1'b1; end
            OP_JALR:   begin iclass = CLS_JALR;  immtype = IMM_I;  legal = 1'b1; end
            OP_STORE:  begin iclass = CLS_STORE; immtype = IMM_S;  legal = 1'b1; end
            OP_JAL:    begin iclass = CLS_JAL;   immtype = IMM_UJ; legal = 1'b1; end
            OP_LUI:    begin iclass = CLS_LUI;   immtype = IMM_U;  legal = 1'b1; end
            OP_AUIPC:  begin iclass = CLS_AUIPC; immtype = IMM_U;  legal = 1'b1; end
            OP_BRANCH: begin
                immtype = IMM_SB;
                // Only beq/bne are supported; other compares are trapped as illegal.
                if (funct3 == F3_BEQ) begin
                    iclass = CLS_BEQ;
                    legal  = 1'b1;
                end else if (funct3 == F3_BNE) begin
                    iclass = CLS_BNE;
                    legal  = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle RISC-V control FSM: FETCH/DECODE/EXEC/MEM/WB with a sticky HALT
// on illegal instructions. Outputs are registered except the branch pc_src and
// the store-completion pc_write, which follow alu_zero / mem_ready directly.
`timescale 1ns/1ps
module control_fsm
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic [2:0]  immtype,
    output logic        ir_write,
    output logic        pc_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic [2:0]  state
);

    state_t   state_q;
    state_t   state_d;
    iclass_t  cls_q;
    iclass_t  cls_sel;
    immtype_t immtype_q;
    ctrl_t    ctrl_q;
    logic     illegal_q;

    iclass_t  dec_cls;
    immtype_t dec_imm;
    logic     dec_legal;

    logic     br_exec;
    logic     br_taken;
    logic     st_done;
    logic     unused_bits;

    opcode_decoder u_dec (
        .opcode  (instruction[6:0]),
        .funct3  (instruction[14:12]),
        .iclass  (dec_cls),
        .immtype (dec_imm),
        .legal   (dec_legal)
    );

    assign unused_bits = ^{instruction[31:15], instruction[11:7]};

    function automatic ctrl_t state_ctrl(input state_t s, input iclass_t c);
        ctrl_t r;
        r = '0;
        case (s)
            S_FETCH: r.ir_write = 1'b1;
            S_EXEC: begin
                r.alu_op = ALU_ADD;
                case (c)
                    CLS_R:       begin r.alu_src_a = 1'b1; r.alu_src_b = 2'b00; r.alu_op = ALU_FUNCT; end
                    CLS_IALU:    begin r.alu_src_a = 1'b1; r.alu_src_b = 2'b01; r.alu_op = ALU_FUNCT; end
                    CLS_LOAD,
                    CLS_STORE:   begin r.alu_src_a = 1'b1; r.alu_src_b = 2'b01; end
                    CLS_AUIPC:   begin r.alu_src_a = 1'b0; r.alu_src_b = 2'b01; end
                    CLS_BEQ,
                    CLS_BNE: begin
                        r.alu_src_a = 1'b1;
                        r.alu_src_b = 2'b00;
                        r.alu_op    = ALU_SUB;
                        r.pc_write  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                r.mem_read  = (c == CLS_LOAD);
                r.mem_write = (c == CLS_STORE);
            end
            S_WB: begin
                r.reg_write = 1'b1;
                r.pc_write  = 1'b1;
                case (c)
                    CLS_LOAD: r.wb_sel = WB_MEM;
                    CLS_LUI:  r.wb_sel = WB_IMM;
                    CLS_JAL:  begin r.wb_sel = WB_PC4; r.pc_src = PC_IMM;     end
                    CLS_JALR: begin r.wb_sel = WB_PC4; r.pc_src = PC_RS1_IMM; end
                    default:  r.wb_sel = WB_ALU;
                endcase
            end
            default: ;
        endcase
        return r;
    endfunction

    function automatic state_t next_state(input state_t s, input iclass_t c,
                                          input logic legal, input logic rdy);
        state_t n;
        case (s)
            S_FETCH:  n = S_DECODE;
            S_DECODE: n = legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                case (c)
                    CLS_BEQ, CLS_BNE:    n = S_FETCH;
                    CLS_LOAD, CLS_STORE: n = S_MEM;
                    default:             n = S_WB;
                endcase
            end
            S_MEM: begin
                if (!rdy)                n = S_MEM;
                else if (c == CLS_LOAD)  n = S_WB;
                else                     n = S_FETCH;
            end
            S_WB:     n = S_FETCH;
            default:  n = S_HALT;
        endcase
        return n;
    endfunction

    // The class is taken straight from the decoder while leaving DECODE so
    // the EXEC outputs can be registered on that same edge.
    assign cls_sel = (state_q == S_DECODE) ? dec_cls : cls_q;
    assign state_d = next_state(state_q, cls_sel, dec_legal, mem_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cls_q     <= CLS_R;
            immtype_q <= IMM_R;
            illegal_q <= 1'b0;
            ctrl_q    <= state_ctrl(S_FETCH, CLS_R);
        end else begin
            state_q   <= state_d;
            ctrl_q    <= state_ctrl(state_d, cls_sel);
            illegal_q <= illegal_q | (state_d == S_HALT);
            if (state_q == S_DECODE) begin
                cls_q <= dec_cls;
                if (dec_legal) begin
                    immtype_q <= dec_imm;
                end
            end
        end
    end

    assign br_exec  = (state_q == S_EXEC) && ((cls_q == CLS_BEQ) || (cls_q == CLS_BNE));
    assign br_taken = (cls_q == CLS_BEQ) ? alu_zero : !alu_zero;
    assign st_done  = (state_q == S_MEM) && (cls_q == CLS_STORE) && mem_ready;

    // Enables are forced low for as long as reset is held, not just after the edge.
    assign ir_write  = ctrl_q.ir_write  & ~reset;
    assign pc_write  = (ctrl_q.pc_write | st_done) & ~reset;
    assign mem_read  = ctrl_q.mem_read  & ~reset;
    assign mem_write = ctrl_q.mem_write & ~reset;
    assign reg_write = ctrl_q.reg_write & ~reset;

    assign pc_src    = br_exec ? (br_taken ? PC_IMM : PC_PLUS4) : ctrl_q.pc_src;
    assign alu_src_a = ctrl_q.alu_src_a;
    assign alu_src_b = ctrl_q.alu_src_b;
    assign alu_op    = ctrl_q.alu_op;
    assign wb_sel    = ctrl_q.wb_sel;
    assign immtype   = immtype_q;
    assign illegal   = illegal_q;
    assign state     = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: per-cycle expected output vectors for each
// instruction class, illegal trapping and reset behaviour.
`timescale 1ns/1ps
module tb_control_fsm;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic        alu_zero;
    logic        mem_ready;
    logic [2:0]  immtype;
    logic        ir_write, pc_write, mem_read, mem_write, reg_write;
    logic [1:0]  pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b, alu_op, wb_sel;
    logic        illegal;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_BEQ   = 32'h00208463;
    localparam logic [31:0] I_BNE   = 32'h00209463;
    localparam logic [31:0] I_BLT3  = 32'h0020A463;
    localparam logic [31:0] I_LW    = 32'h0000A103;
    localparam logic [31:0] I_SW    = 32'h0020A023;
    localparam logic [31:0] I_JAL   = 32'h0000006F;
    localparam logic [31:0] I_LUI   = 32'h000000B7;
    localparam logic [31:0] I_JALR  = 32'h00008067;
    localparam logic [31:0] I_ADDI  = 32'h00108093;
    localparam logic [31:0] I_AUIPC = 32'h00000097;
    localparam logic [31:0] I_BAD   = 32'h0000007F;

    typedef struct packed {
        logic        rst;
        logic        az;
        logic        rdy;
        logic [31:0] ins;
        logic [20:0] ex;
    } vec_t;

    logic [20:0] obs;
    assign obs = {state, immtype, illegal, ir_write, pc_write, mem_read, mem_write,
                  reg_write, pc_src, alu_src_a, alu_src_b, alu_op, wb_sel};

    control_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .alu_zero    (alu_zero),
        .mem_ready   (mem_ready),
        .immtype     (immtype),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .pc_src      (pc_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .wb_sel      (wb_sel),
        .illegal     (illegal),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector: state, immtype, illegal, ir, pcw, mrd, mwr, rw, pc_src, src_a, src_b, alu_op, wb_sel
    function automatic logic [20:0] ev(input int st, input int imm, input int ill, input int ir,
                                       input int pcw, input int mr, input int mw, input int rw,
                                       input int pcs, input int sa, input int sb, input int op,
                                       input int wb);
        return {st[2:0], imm[2:0], ill[0], ir[0], pcw[0], mr[0], mw[0], rw[0],
                pcs[1:0], sa[0], sb[1:0], op[1:0], wb[1:0]};
    endfunction

    function automatic logic [20:0] e_fetch(input int imm);
        return ev(0, imm, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic logic [20:0] e_dec(input int imm);
        return ev(1, imm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic vec_t mk(input logic rst, input logic az, input logic rdy,
                                input logic [31:0] ins, input logic [20:0] ex);
        return {rst, az, rdy, ins, ex};
    endfunction

    task automatic do_reset();
        reset = 1'b1; instruction = 32'h0; alu_zero = 1'b0; mem_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; instruction = I_ADD; alu_zero = 1'b1; mem_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++;
        if (obs !== ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            $display("FAIL reset_hold got %h exp %h", obs, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            errors++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        vec_t v[$];
        do_reset();
        v.push_back(mk(0, 0, 0, I_ADD, e_fetch(0)));
        v.push_back(mk(0, 0, 0, I_ADD, e_dec(0)));
        v.push_back(mk(0, 0, 0, I_ADD, ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0)));
        v.push_back(mk(0, 0, 0, I_ADD, ev(4, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0)));
        v.push_back(mk(0, 0, 0, I_ADD, e_fetch(0)));
        for (int i = 0; i < v.size(); i++) begin
            reset = v[i].rst; alu_zero = v[i].az; mem_ready = v[i].rdy; instruction = v[i].ins;
            @(negedge clk);
            checks++;
            if (obs !== v[i].ex) begin
                $display("FAIL add cyc %0d got %h exp %h", i + 1, obs, v[i].ex);
                errors++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        vec_t v[$];
        do_reset();
        v.push_back(mk(0, 0, 0, I_BEQ, e_fetch(0)));
        v.push_back(mk(0, 0, 0, I_BEQ, e_dec(0)));
        v.push_back(mk(0, 1, 0, I_BEQ, ev(2, 3, 0, 0, 1, 0, 0, 0, 1, 1, 0, 1, 0)));
        v.push_back(mk(0, 0, 0, I_BEQ, e_fetch(3)));
        v.push_back(mk(0, 0, 0, I_BEQ, e_dec(3)));
        v.push_back(mk(0, 0, 0, I_BEQ, ev(2, 3, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0)));
        v.push_back(mk(0, 0, 0, I_BNE, e_fetch(3)));
        v.push_back(mk(0, 0, 0, I_BNE, e_dec(3)));
        v.push_back(mk(0, 0, 0, I_BNE, ev(2, 3, 0, 0, 1, 0, 0, 0, 1, 1, 0, 1, 0)));
        v.push_back(mk(0, 0, 0, I_BNE, e_fetch(3)));
        v.push_back(mk(0, 0, 0, I_BNE, e_dec(3)));
        v.push_back(mk(0, 1, 0, I_BNE, ev(2, 3, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0)));
        v.push_back(mk(0, 0, 0, I_BNE, e_fetch(3)));
        for (int i = 0; i < v.size(); i++) begin
            reset = v[i].rst; alu_zero = v[i].az; mem_ready = v[i].rdy; instruction = v[i].ins;
            @(negedge clk);
            checks++;
            if (obs !== v[i].ex) begin
                $display("FAIL branch cyc %0d got %h exp %h", i + 1, obs, v[i].ex);
                errors++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_store();
        vec_t v[$];
        do_reset();
        v.push_back(mk(0, 0, 0, I_LW, e_fetch(0)));
        v.push_back(mk(0, 0, 0, I_LW, e_dec(0)));
        v.push_back(mk(0, 0, 0, I_LW, ev(2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0)));
        v.push_back(mk(0, 0, 0, I_LW, ev(3, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)));
        v.push_back(mk(0, 0, 0, I_LW, ev(3, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)));
        v.push_back(mk(0, 0, 0, I_LW, ev(3, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)));
        v.push_back(mk(0, 0, 1, I_LW, ev(3, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)));
        v.push_back(mk(0, 0, 0, I_LW, ev(4, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1)));
        v.push_back(mk(0, 0, 0, I_SW, e_fetch(1)));
        v.push_back(mk(0, 0, 0, I_SW, e_dec(1)));
        v.push_back(mk(0, 0, 0, I_SW, ev(2, 2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0)));
        v.push_back(mk(0, 0, 1, I_SW, ev(3, 2, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0)));
        v.push_back(mk(0, 0, 0, I_SW, e_fetch(2)));
        v.push_back(mk(0, 0, 0, I_SW, e_dec(2)));
        v.push_back(mk(0, 0, 0, I_SW, ev(2, 2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0)));
        v.push_back(mk(0, 0, 0, I_SW, ev(3, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)));
        // reset lands in the middle of the store's memory wait
        v.push_back(mk(1, 0, 0, I_SW, ev(3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        v.push_back(mk(0, 0, 0, I_SW, e_fetch(0)));
        for (int i = 0; i < v.size(); i++) begin
            reset = v[i].rst; alu_zero = v[i].az; mem_ready = v[i].rdy; instruction = v[i].ins;
            @(negedge clk);
            checks++;
            if (obs !== v[i].ex) begin
                $display("FAIL loadstore cyc %0d got %h exp %h", i + 1, obs, v[i].ex);
                errors++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        vec_t v[$];
        logic [20:0] msk;
        msk = ~(21'h7 << 15);
        do_reset();
        v.push_back(mk(0, 0, 0, I_BAD, e_fetch(0)));
        v.push_back(mk(0, 0, 0, I_BAD, e_dec(0)));
        for (int k = 0; k < 10; k++) begin
            v.push_back(mk(0, k[0], k[1], I_BAD, ev(5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        end
        v.push_back(mk(1, 0, 0, I_BLT3, ev(5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        v.push_back(mk(0, 0, 0, I_BLT3, e_fetch(0)));
        v.push_back(mk(0, 0, 0, I_BLT3, e_dec(0)));
        for (int k = 0; k < 3; k++) begin
            v.push_back(mk(0, 1, 1, I_BLT3, ev(5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        end
        v.push_back(mk(1, 0, 0, I_ADD, ev(5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        v.push_back(mk(0, 0, 0, I_ADD, e_fetch(0)));
        for (int i = 0; i < v.size(); i++) begin
            reset = v[i].rst; alu_zero = v[i].az; mem_ready = v[i].rdy; instruction = v[i].ins;
            @(negedge clk);
            checks++;
            if ((obs & msk) !== (v[i].ex & msk)) begin
                $display("FAIL illegal cyc %0d got %h exp %h", i + 1, obs & msk, v[i].ex & msk);
                errors++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[$];
        do_reset();
        v.push_back(mk(0, 0, 0, I_JAL, e_fetch(0)));
        v.push_back(mk(0, 0, 0, I_JAL, e_dec(0)));
        v.push_back(mk(0, 0, 0, I_JAL, ev(2, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        v.push_back(mk(0, 0, 0, I_JAL, ev(4, 4, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 2)));
        v.push_back(mk(0, 0, 0, I_LUI, e_fetch(4)));
        v.push_back(mk(0, 0, 0, I_LUI, e_dec(4)));
        v.push_back(mk(0, 0, 0, I_LUI, ev(2, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        v.push_back(mk(0, 0, 0, I_LUI, ev(4, 5, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 3)));
        v.push_back(mk(0, 0, 0, I_JALR, e_fetch(5)));
        v.push_back(mk(0, 0, 0, I_JALR, e_dec(5)));
        v.push_back(mk(0, 0, 0, I_JALR, ev(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        v.push_back(mk(0, 0, 0, I_JALR, ev(4, 1, 0, 0, 1, 0, 0, 1, 2, 0, 0, 0, 2)));
        v.push_back(mk(0, 0, 0, I_ADDI, e_fetch(1)));
        v.push_back(mk(0, 0, 0, I_ADDI, e_dec(1)));
        v.push_back(mk(0, 0, 0, I_ADDI, ev(2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0)));
        v.push_back(mk(0, 0, 0, I_ADDI, ev(4, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0)));
        v.push_back(mk(0, 0, 0, I_AUIPC, e_fetch(1)));
        v.push_back(mk(0, 0, 0, I_AUIPC, e_dec(1)));
        v.push_back(mk(0, 0, 0, I_AUIPC, ev(2, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)));
        v.push_back(mk(0, 0, 0, I_AUIPC, ev(4, 5, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0)));
        v.push_back(mk(0, 0, 0, I_AUIPC, e_fetch(5)));
        for (int i = 0; i < v.size(); i++) begin
            reset = v[i].rst; alu_zero = v[i].az; mem_ready = v[i].rdy; instruction = v[i].ins;
            @(negedge clk);
            checks++;
            if (obs !== v[i].ex) begin
                $display("FAIL b2b cyc %0d got %h exp %h", i + 1, obs, v[i].ex);
                errors++;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; instruction = 32'h0; alu_zero = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_add();
        test_branch();
        test_load_store();
        test_illegal();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
